// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one downstream memory port between icache and dcache with round-robin grant
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              proto_err
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  state_t state, state_nx;
  logic last_d, last_d_nx;
  logic wr_q, wr_nx;
  logic perr_q, perr_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [LINE_W-1:0] wdata_q, wdata_nx;
  logic d_req, grant_d, grant_i;
  assign d_req = d_read | d_write;
  // on conflict the requester that did not win last time gets the port
  assign grant_d = d_req && (!i_read || !last_d);
  assign grant_i = i_read && !grant_d;
  always_comb begin
    state_nx = state;
    last_d_nx = last_d;
    wr_nx = wr_q;
    addr_nx = addr_q;
    wdata_nx = wdata_q;
    perr_nx = perr_q | (d_read & d_write);
    if (state == IDLE) begin
      perr_nx = perr_nx | mem_resp;
      if (grant_d) begin
        state_nx = BUSY_D;
        last_d_nx = 1'b1;
        wr_nx = d_write;
        addr_nx = d_addr;
        wdata_nx = d_wdata;
      end else if (grant_i) begin
        state_nx = BUSY_I;
        last_d_nx = 1'b0;
        wr_nx = 1'b0;
        addr_nx = i_addr;
      end
    end else begin
      perr_nx = perr_nx | (state == BUSY_I ? !i_read : !d_req);
      state_nx = mem_resp ? IDLE : state;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      last_d <= 1'b0;
      wr_q <= 1'b0;
      perr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nx;
      last_d <= last_d_nx;
      wr_q <= wr_nx;
      perr_q <= perr_nx;
      addr_q <= addr_nx;
      wdata_q <= wdata_nx;
    end
  end
  assign mem_read = (state != IDLE) && !wr_q;
  assign mem_write = (state != IDLE) && wr_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign proto_err = perr_q;
  assign i_resp = (state == BUSY_I) && mem_resp;
  assign d_resp = (state == BUSY_D) && mem_resp;
  assign i_rdata = rst ? mem_rdata : '0;
  assign d_rdata = rst ? mem_rdata : '0;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: randomized scoreboard bench with a round-robin transaction-order model
module tb_cache_mem_arbiter;
  logic clk, rst;
  logic i_read, i_resp, d_read, d_write, d_resp;
  logic mem_read, mem_write, mem_resp, proto_err;
  logic [31:0] i_addr, d_addr, mem_addr;
  logic [255:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;

  cache_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .proto_err(proto_err)
  );

  typedef struct {
    bit who;
    bit wr;
    logic [31:0] addr;
    logic [255:0] wdata;
  } tx_t;

  tx_t q[$];
  tx_t cur;
  int vecs = 0, fails = 0;
  int i_cnt = 0, d_cnt = 0;
  int fix_lat = -1;
  bit mem_en = 1, exp_perr = 0, last = 0, in_tx = 0, prev_b = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [255:0] rnd_line();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic fail(input string n);
    vecs++;
    fails++;
    $display("FAIL %s", n);
  endtask

  // Reference: requests held continuously are served in rotation, alternating whenever both wait
  task automatic plan(input int ni, input int nd, input bit wr, input logic [31:0] ia,
                      input logic [31:0] da, input logic [255:0] wd);
    bit who;
    while (ni + nd > 0) begin
      who = (ni > 0 && nd > 0) ? !last : (nd > 0);
      q.push_back('{who, who ? wr : 1'b0, who ? da : ia, wd});
      if (who) nd--; else ni--;
      last = who;
    end
  endtask

  // downstream memory: random (or fixed) latency, random read data
  initial begin
    int cnt;
    bit act;
    act = 0;
    cnt = 0;
    mem_resp = 0;
    forever begin
      @(negedge clk);
      if (!mem_en || !rst) act = 0;
      else if (mem_read || mem_write) begin
        if (!act) begin
          act = 1;
          cnt = fix_lat >= 0 ? fix_lat : int'($urandom_range(0, 4));
        end
        if (cnt == 0) begin
          @(posedge clk); #1;
          mem_rdata = rnd_line();
          mem_resp = 1;
          @(posedge clk); #1;
          mem_resp = 0;
          act = 0;
        end else cnt--;
      end
    end
  end

  // monitor: pops the expected transaction when the downstream request appears
  initial begin
    logic b;
    forever begin
      @(negedge clk);
      b = mem_read | mem_write;
      if (!rst) in_tx = 0;
      chk("one_op", {255'b0, mem_read & mem_write}, 256'd0);
      if (b && !in_tx) begin
        chk("idle_gap", {255'b0, prev_b}, 256'd0);
        if (q.size() == 0) fail("unexpected_tx");
        else cur = q.pop_front();
        in_tx = 1;
      end
      if (in_tx) begin
        chk("mem_write", {255'b0, mem_write}, {255'b0, cur.wr});
        chk("mem_read", {255'b0, mem_read}, {255'b0, !cur.wr});
        chk("mem_addr", {224'b0, mem_addr}, {224'b0, cur.addr});
        if (cur.wr) chk("mem_wdata", mem_wdata, cur.wdata);
      end
      chk("i_resp", {255'b0, i_resp}, {255'b0, mem_resp && in_tx && !cur.who});
      chk("d_resp", {255'b0, d_resp}, {255'b0, mem_resp && in_tx && cur.who});
      if (mem_resp && in_tx) begin
        if (cur.who) begin
          chk("d_rdata", d_rdata, mem_rdata);
          d_cnt++;
        end else begin
          chk("i_rdata", i_rdata, mem_rdata);
          i_cnt++;
        end
        in_tx = 0;
      end
      chk("proto_err", {255'b0, proto_err}, {255'b0, exp_perr});
      prev_b = b;
    end
  end

  task automatic reset_dut();
    @(posedge clk); #2;
    rst = 0;
    q.delete();
    last = 0;
    exp_perr = 0;
    i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
    mem_rdata = rnd_line();
    #1;
    chk("rst_mem_read", {255'b0, mem_read}, 256'd0);
    chk("rst_mem_write", {255'b0, mem_write}, 256'd0);
    chk("rst_mem_addr", {224'b0, mem_addr}, 256'd0);
    chk("rst_mem_wdata", mem_wdata, 256'd0);
    chk("rst_resp", {254'b0, i_resp, d_resp}, 256'd0);
    chk("rst_proto_err", {255'b0, proto_err}, 256'd0);
    chk("rst_i_rdata", i_rdata, 256'd0);
    chk("rst_d_rdata", d_rdata, 256'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1;
  endtask

  task automatic complete(input int ni, input int nd, input bit flip, input bit drop_i);
    bit done;
    done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clk); #1;
      if (flip && c == 0) d_wdata = ~d_wdata;
      if (drop_i && c == 0) i_read = 0;
      if (drop_i && c == 1) exp_perr = 1;
      if (i_cnt >= ni) i_read = 0;
      if (d_cnt >= nd) begin
        d_read = 0;
        d_write = 0;
      end
      done = (i_cnt >= ni) && (d_cnt >= nd);
    end
    if (!done) fail("timeout");
  endtask

  task automatic round(input int ni, input int nd, input bit drd, input bit dwr,
                       input logic [31:0] ia, input logic [31:0] da, input logic [255:0] wd,
                       input bit flip, input bit drop_i);
    @(posedge clk); #1;
    i_cnt = 0;
    d_cnt = 0;
    plan(ni, nd, dwr, ia, da, wd);
    i_read = ni > 0; i_addr = ia;
    d_read = nd > 0 && drd; d_write = nd > 0 && dwr;
    d_addr = da; d_wdata = wd;
    @(negedge clk);
    chk("arb_wait", {255'b0, mem_read | mem_write}, 256'd0);
    if (d_read && d_write) exp_perr = 1;
    @(negedge clk);
    chk("arb_grant", {255'b0, mem_read | mem_write}, 256'd1);
    complete(ni, nd, flip, drop_i);
  endtask

  task automatic rnd_round();
    int k;
    bit w;
    k = $urandom_range(0, 2);
    w = 1'($urandom_range(0, 1));
    round(k != 1, k != 0, !w, w, $urandom & 32'hFFFF_FFE0, $urandom & 32'hFFFF_FFE0,
          rnd_line(), k == 1 && w, 0);
  endtask

  initial begin
    rst = 0;
    i_read = 0; i_addr = 0; d_read = 0; d_write = 0; d_addr = 0; d_wdata = 0;
    mem_rdata = rnd_line();
    reset_dut();
    fix_lat = 4;
    round(1, 0, 0, 0, 32'h40, 32'h0, '0, 0, 0);
    fix_lat = -1;
    round(0, 1, 0, 1, 32'h0, 32'h100, {8{32'hDEADBEEF}}, 1, 0);
    reset_dut();
    round(1, 1, 1, 0, 32'h200, 32'h300, rnd_line(), 0, 0);
    round(1, 1, 1, 0, 32'h220, 32'h320, rnd_line(), 0, 0);
    reset_dut();
    round(1, 2, 1, 0, 32'h400, 32'h500, rnd_line(), 0, 0);
    for (int r = 0; r < 30; r++) rnd_round();
    // reset two cycles into a dcache transaction the memory never answers
    mem_en = 0;
    @(posedge clk); #1;
    i_cnt = 0; d_cnt = 0;
    plan(0, 1, 0, 32'h0, 32'h600, '0);
    d_read = 1; d_addr = 32'h600;
    @(negedge clk); @(negedge clk);
    chk("busy_before_rst", {255'b0, mem_read}, 256'd1);
    @(posedge clk); @(posedge clk); #2;
    rst = 0;
    #1;
    chk("rst_drop_mem_read", {255'b0, mem_read}, 256'd0);
    chk("rst_no_d_resp", {255'b0, d_resp}, 256'd0);
    q.delete();
    last = 0;
    plan(0, 1, 0, 32'h0, 32'h600, '0);
    @(posedge clk); #2;
    rst = 1;
    mem_en = 1;
    @(negedge clk);
    chk("regrant_wait", {255'b0, mem_read}, 256'd0);
    @(negedge clk);
    chk("regrant", {255'b0, mem_read}, 256'd1);
    complete(0, 1, 0, 0);
    fix_lat = 3;
    round(1, 0, 0, 0, 32'h80, 32'h0, '0, 0, 1);
    fix_lat = -1;
    rnd_round();
    reset_dut();
    mem_en = 0;
    @(posedge clk); #1;
    mem_rdata = rnd_line();
    mem_resp = 1;
    @(posedge clk); #1;
    mem_resp = 0;
    exp_perr = 1;
    mem_en = 1;
    rnd_round();
    rnd_round();
    reset_dut();
    round(0, 1, 1, 1, 32'h0, 32'h700, rnd_line(), 0, 0);
    rnd_round();
    reset_dut();
    rnd_round();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single downstream memory port (L2/physical memory) between the instruction cache (IF) and the data cache (MEM stage data_* path).
- Accepts cacheline read/write requests from both, grants one at a time with round-robin on contention, and latches the granted request for the full transaction.
- Routes the response back to the granted requester only. Sits between the two L1 caches and the memory model in the cpu top level.

Parameters:
- ADDR_W, 32, address width (line-aligned byte address).
- LINE_W, 256, cacheline data width.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- i_read  input  1  icache line read request, held until i_resp.
- i_addr  input  ADDR_W  icache request address.
- i_rdata  output  LINE_W  line returned to icache.
- i_resp  output  1  one-cycle completion pulse to icache.
- d_read  input  1  dcache line read request, held until d_resp.
- d_write  input  1  dcache line writeback request, held until d_resp.
- d_addr  input  ADDR_W  dcache request address.
- d_wdata  input  LINE_W  dcache writeback line.
- d_rdata  output  LINE_W  line returned to dcache.
- d_resp  output  1  one-cycle completion pulse to dcache.
- mem_read  output  1  downstream read, held until mem_resp.
- mem_write  output  1  downstream write, held until mem_resp.
- mem_addr  output  ADDR_W  latched downstream address.
- mem_wdata  output  LINE_W  latched downstream write line.
- mem_rdata  input  LINE_W  downstream read line, valid with mem_resp.
- mem_resp  input  1  downstream completion, one-cycle pulse.
- proto_err  output  1  sticky protocol-violation flag.

Behaviour:
- States: IDLE, BUSY_I, BUSY_D.
- Reset (rst low, async): state IDLE, last_grant = I (so D wins the first conflict), latches cleared. All outputs 0 until the first post-reset edge: mem_read, mem_write, mem_addr, mem_wdata, i_resp, d_resp, proto_err. i_rdata and d_rdata are also 0 during reset.
- IDLE:
  - Only i_read asserted: go to BUSY_I.
  - Only d_read or d_write asserted: go to BUSY_D.
  - Both requesters asserted: grant the one not equal to last_grant.
  - On grant, latch addr, wdata (D only) and the op (read/write) into internal registers, and update last_grant.
  - No request: stay in IDLE.
- Arbitration latency is 1 cycle: the request is seen in IDLE, and mem_read/mem_write assert in the next cycle.
- BUSY_x:
  - mem_read/mem_write, mem_addr and mem_wdata are driven from the latched registers only and are stable for the whole transaction.
  - Exactly one of mem_read/mem_write is high.
  - On mem_resp: assert x_resp combinationally in the same cycle, with x_rdata = mem_rdata. Return to IDLE; mem_read/mem_write are 0 from the next cycle.
- i_rdata and d_rdata pass mem_rdata through continuously. Only the resp strobes are qualified, and the non-granted resp is never asserted.
- Back-to-back transactions: at least one IDLE cycle separates them, so mem_read/mem_write drop for ≥1 cycle between transactions.
- Simultaneous d_read and d_write: a protocol violation. Treat it as a write, and set proto_err.
- proto_err is also set if the granted requester deasserts its request before resp. The latched transaction still completes and still pulses resp.
- proto_err clears only on reset.
- mem_resp seen in IDLE: ignored, no resp pulse, and proto_err is set.
- Requests arriving while BUSY are not sampled. They wait, held by the requester, until the next IDLE.
- Reset mid-transaction: returns to IDLE immediately and drops the downstream request. No resp is issued for the aborted transaction.

Test Plan:
- Single icache read to addr 0x0000_0040 with mem_resp 5 cycles after mem_read rises:
  - mem_read rises 1 cycle after i_read and mem_addr = 0x40.
  - i_resp pulses once, in the same cycle as mem_resp, with i_rdata = mem_rdata.
  - d_resp stays 0 throughout.
- dcache writeback to addr 0x100 with d_wdata = {8{32'hDEADBEEF}}:
  - mem_write is held and mem_wdata matches, stable even if d_wdata changes mid-transaction.
  - d_resp pulses on mem_resp.
- i_read and d_read asserted together out of reset:
  - D is granted first.
  - After d_resp, one IDLE cycle follows, then I is granted.
  - A second simultaneous conflict grants the opposite requester from the first.
- Continuous d_read with a pending i_read: grants alternate D, I, D, and neither requester waits more than one transaction.
- Reset pulled low 2 cycles into BUSY_D:
  - mem_read goes to 0 asynchronously.
  - No d_resp is issued.
  - After reset release with d_read still high, a fresh grant is issued.
- Protocol violations:
  - Drop i_read mid-transaction: proto_err is set and i_resp still pulses.
  - Inject mem_resp while in IDLE: proto_err stays 1 until reset.
